ewb_arbiter: RTL and testbench
==============================

# ewb_arbiter

Single-port memory arbiter between the cache read-miss path and the eviction write buffer (EWB) drain. It sits between the L2/LLC miss interface and the physical memory (cacheline adaptor) port. Each transaction is a full cacheline. The arbiter serializes read fills and buffered write-backs and enforces read-after-write ordering on the same line. A bounded-starvation counter guarantees the write buffer drains under continuous read traffic.

## Interface
- LINE_WIDTH, 256, cacheline data width in bits
- ADDR_WIDTH, 32, byte address width
- OFFSET_BITS, 5, line offset bits ignored in address compare
- MAX_READ_STREAK, 4, consecutive read grants allowed while a write is pending before a write is forced (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_read_i  in  1  read-miss request, held until rd_resp_o
- rd_address_i  in  ADDR_WIDTH  read line address
- rd_rdata_o  out  LINE_WIDTH  fill data, valid with rd_resp_o
- rd_resp_o  out  1  one-cycle read completion pulse
- wb_write_i  in  1  EWB drain request, held until wb_resp_o
- wb_address_i  in  ADDR_WIDTH  write line address
- wb_wdata_i  in  LINE_WIDTH  write line data
- wb_resp_o  out  1  one-cycle write completion pulse
- mem_read_o  out  1  memory read command
- mem_write_o  out  1  memory write command
- mem_address_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  LINE_WIDTH  memory write data
- mem_rdata_i  in  LINE_WIDTH  memory read data
- mem_resp_i  in  1  memory completion pulse

## Operation
- States: IDLE, RD, WR. Reset → IDLE, streak = 0, latched address/data = 0.
- IDLE arbitration, evaluated each cycle:
  - no request → stay IDLE
  - read only → RD
  - write only → WR
  - both pending and line addresses equal (bits ADDR_WIDTH-1:OFFSET_BITS) → WR (RAW hazard; the write drains before the read)
  - both pending, streak == MAX_READ_STREAK → WR
  - both pending, otherwise → RD
- On a grant, the winner's address (and wdata for WR) is latched. mem_address_o and mem_wdata_o are driven from the latches, never from live inputs.
- RD: mem_read_o = 1. On mem_resp_i: rd_resp_o = 1, rd_rdata_o = mem_rdata_i (same cycle), next state IDLE.
- WR: mem_write_o = 1. On mem_resp_i: wb_resp_o = 1, next state IDLE.
- Streak counter (width ≥ clog2(MAX_READ_STREAK+1)):
  - +1 on an RD grant while wb_write_i = 1, saturating at MAX_READ_STREAK
  - cleared on any WR grant
  - unchanged on an RD grant with no write pending
- Outside RD/WR, mem_read_o = mem_write_o = 0 and both resp outputs are 0. rd_rdata_o = 0 unless in RD with mem_resp_i high.
- mem_resp_i in IDLE is ignored (no resp output, no state change).
- mem_read_o and mem_write_o are never both 1.

## Timing
- Moore commands: a request seen in IDLE at cycle n produces mem_read_o/mem_write_o at cycle n+1.
- Requester resp is combinational from mem_resp_i in the same cycle. The state returns to IDLE at the next edge.
- Minimum transaction: grant cycle + 1 command cycle = 2 cycles. With back-to-back requests, IDLE lasts exactly 1 cycle between transactions.
- Requesters drop their request the cycle after resp. IDLE therefore never re-grants a completed request.
- Reset mid-transaction: next cycle in IDLE, all outputs 0, streak 0. The in-flight memory operation is abandoned; the memory side must tolerate command withdrawal.
- Request inputs changing while in RD/WR have no effect until IDLE.

## Test plan
- Reset: assert rst for 2 cycles mid-WR → next cycle all outputs 0, state IDLE, a later mem_resp_i produces no resp.
- Single read: rd_read_i=1, addr 0x0000_1040, mem_resp_i at 3rd command cycle with data 0xA5…A5 → mem_read_o high cycles 1–3, mem_address_o=0x0000_1040, rd_resp_o pulse cycle 3 with that data.
- Single write: wb_write_i=1, addr 0x0000_2000, data 0x1234… → mem_write_o high from cycle 1, mem_wdata_o matches, wb_resp_o pulses exactly on mem_resp_i.
- RAW hazard: read 0x0000_3004 and write 0x0000_3018 asserted in the same cycle (same line) → WR granted first, then RD. The memory sees the write before the read.
- Starvation bound: write to 0x0000_5000 pending; reads to distinct lines issued back-to-back → exactly 4 RD grants, then WR, then streak 0 and reads resume.
- Mutual exclusion: randomized requests and memory latencies 1–8 cycles → never mem_read_o & mem_write_o. Each request gets exactly one resp. The address stays stable for the whole command.

Source files
------------

// File: rtl/ewb_arbiter.sv
// ewb_arbiter
// Single-port memory arbiter between the cache read-miss path and the
// eviction write buffer (EWB) drain. Every transaction is one full cacheline.
// Reads and buffered write-backs are serialised onto one memory port. A write
// to the same line as a pending read always drains first (read-after-write
// ordering). A streak counter bounds how long reads can starve the EWB.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rd_read_i/rd_address_i   read-miss request (held until rd_resp_o)
//   rd_rdata_o/rd_resp_o     fill data and one-cycle completion pulse
//   wb_write_i/wb_address_i/wb_wdata_i  EWB drain request (held until wb_resp_o)
//   wb_resp_o                one-cycle write completion pulse
//   mem_read_o/mem_write_o   memory commands (Moore, never both high)
//   mem_address_o/mem_wdata_o  latched command address / data
//   mem_rdata_i/mem_resp_i   memory read data and completion pulse
module ewb_arbiter #(
    parameter int LINE_WIDTH      = 256,
    parameter int ADDR_WIDTH      = 32,
    parameter int OFFSET_BITS     = 5,
    parameter int MAX_READ_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_read_i,
    input  logic [ADDR_WIDTH-1:0] rd_address_i,
    output logic [LINE_WIDTH-1:0] rd_rdata_o,
    output logic                  rd_resp_o,
    input  logic                  wb_write_i,
    input  logic [ADDR_WIDTH-1:0] wb_address_i,
    input  logic [LINE_WIDTH-1:0] wb_wdata_i,
    output logic                  wb_resp_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [LINE_WIDTH-1:0] mem_wdata_o,
    input  logic [LINE_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_resp_i
);

    localparam int STREAK_W = $clog2(MAX_READ_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_READ_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    state_e                state_q,  state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [LINE_WIDTH-1:0] wdata_q,  wdata_d;
    logic                  same_line_s;

    // Arbitration, latch capture and streak bookkeeping
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        same_line_s = (rd_address_i[ADDR_WIDTH-1:OFFSET_BITS] ==
                       wb_address_i[ADDR_WIDTH-1:OFFSET_BITS]);
        case (state_q)
            ST_IDLE: begin
                // The write wins when alone, on a same-line hazard, or once
                // reads have used up their allowed streak.
                if (wb_write_i && (!rd_read_i || same_line_s || (streak_q == STREAK_MAX))) begin
                    state_d  = ST_WR;
                    addr_d   = wb_address_i;
                    wdata_d  = wb_wdata_i;
                    streak_d = '0;
                end else if (rd_read_i) begin
                    state_d = ST_RD;
                    addr_d  = rd_address_i;
                    // Only reads that bypass a waiting write count toward the streak.
                    if (wb_write_i && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = streak_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (mem_resp_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (mem_resp_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, streak and command latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            streak_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Commands decode the state register; completions pass mem_resp_i straight through.
    always_comb begin
        mem_read_o    = (state_q == ST_RD);
        mem_write_o   = (state_q == ST_WR);
        mem_address_o = addr_q;
        mem_wdata_o   = wdata_q;
        rd_resp_o     = (state_q == ST_RD) && mem_resp_i;
        wb_resp_o     = (state_q == ST_WR) && mem_resp_i;
        if ((state_q == ST_RD) && mem_resp_i) begin
            rd_rdata_o = mem_rdata_i;
        end else begin
            rd_rdata_o = '0;
        end
    end

endmodule

// File: tb/tb_ewb_arbiter.sv
module tb_ewb_arbiter;

    localparam int MAXS = 4;

    logic         clk;
    logic         rst;
    logic         rd_read_i;
    logic [31:0]  rd_address_i;
    logic [255:0] rd_rdata_o;
    logic         rd_resp_o;
    logic         wb_write_i;
    logic [31:0]  wb_address_i;
    logic [255:0] wb_wdata_i;
    logic         wb_resp_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [31:0]  mem_address_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_resp_i;

    ewb_arbiter #(
        .LINE_WIDTH(256), .ADDR_WIDTH(32), .OFFSET_BITS(5), .MAX_READ_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_read_i(rd_read_i), .rd_address_i(rd_address_i),
        .rd_rdata_o(rd_rdata_o), .rd_resp_o(rd_resp_o),
        .wb_write_i(wb_write_i), .wb_address_i(wb_address_i),
        .wb_wdata_i(wb_wdata_i), .wb_resp_o(wb_resp_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_address_o(mem_address_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference: which transfer the memory should be serving
    // (0 none, 1 read, 2 write), with what address/data, and the read streak.
    int           m_busy = 0;
    logic [31:0]  m_addr = 32'h0;
    logic [255:0] m_wdata = 256'h0;
    int           m_streak = 0;
    int           m_cnt = 0;
    int           m_lat = 1;
    bit           rd_done = 1'b0;
    bit           wb_done = 1'b0;

    // Environment knobs
    int           fixed_lat = 0;
    bit           idle_noise = 1'b0;
    bit           force_idle_resp = 1'b0;
    bit           pat_en = 1'b0;
    bit           chk_en = 1'b0;

    // Observations
    int           obs[$];
    bit           prev_cmd = 1'b0;
    int           n_rd_resp = 0;
    int           n_wb_resp = 0;
    int           n_rd_cmd_cycles = 0;
    logic [255:0] last_rdata = 256'h0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_seq(input string tag, input int expq[$]);
        check_val({tag, "_len"}, 256'(obs.size()), 256'(expq.size()));
        for (int i = 0; i < expq.size() && i < obs.size(); i++)
            check_val(tag, 256'(obs[i]), 256'(expq[i]));
    endtask

    // One clock cycle: drive memory side, check outputs, advance the model.
    task automatic tick();
        bit cmd;
        if (m_busy != 0) mem_resp_i = (m_cnt == m_lat - 1);
        else if (idle_noise) mem_resp_i = ($urandom_range(0, 3) == 0);
        else mem_resp_i = force_idle_resp;
        mem_rdata_i = pat_en ? {32{8'hA5}} : rand_line();
        #1;
        if (chk_en) begin
            check_val("mem_read",  256'(mem_read_o),  256'(m_busy == 1));
            check_val("mem_write", 256'(mem_write_o), 256'(m_busy == 2));
            check_val("mem_addr",  256'(mem_address_o), 256'(m_addr));
            check_val("mem_wdata", mem_wdata_o, m_wdata);
            check_val("rd_resp", 256'(rd_resp_o), 256'((m_busy == 1) && mem_resp_i));
            check_val("wb_resp", 256'(wb_resp_o), 256'((m_busy == 2) && mem_resp_i));
            check_val("rd_rdata", rd_rdata_o, ((m_busy == 1) && mem_resp_i) ? mem_rdata_i : 256'h0);
            check_val("excl", 256'(mem_read_o && mem_write_o), 256'h0);
        end
        cmd = mem_read_o || mem_write_o;
        if (cmd && !prev_cmd) obs.push_back(mem_write_o ? 2 : 1);
        prev_cmd = cmd;
        if (mem_read_o) n_rd_cmd_cycles++;
        if (rd_resp_o) begin n_rd_resp++; last_rdata = rd_rdata_o; end
        if (wb_resp_o) n_wb_resp++;
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_streak = 0; m_addr = 32'h0; m_wdata = 256'h0;
        end else if (m_busy != 0) begin
            if (mem_resp_i) begin
                if (m_busy == 1) rd_done = 1'b1; else wb_done = 1'b1;
                m_busy = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            int win;
            win = 0;
            if (rd_read_i && wb_write_i)
                win = ((rd_address_i[31:5] == wb_address_i[31:5]) || (m_streak == MAXS)) ? 2 : 1;
            else if (rd_read_i) win = 1;
            else if (wb_write_i) win = 2;
            if (win == 1) begin
                m_addr = rd_address_i;
                if (wb_write_i && m_streak < MAXS) m_streak++;
            end else if (win == 2) begin
                m_addr = wb_address_i;
                m_wdata = wb_wdata_i;
                m_streak = 0;
            end
            m_busy = win;
            m_cnt = 0;
            m_lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 8);
        end
        @(negedge clk);
        if (rd_done) begin rd_read_i = 1'b0; rd_done = 1'b0; end
        if (wb_done) begin wb_write_i = 1'b0; wb_done = 1'b0; end
    endtask

    initial begin
        int exp_q[$];
        int base_rd;
        int base_wb;
        int reads_left;
        int writes_left;
        int issued_rd;
        int issued_wb;
        rst = 1'b1;
        rd_read_i = 1'b0; rd_address_i = 32'h0;
        wb_write_i = 1'b0; wb_address_i = 32'h0; wb_wdata_i = 256'h0;
        mem_rdata_i = 256'h0; mem_resp_i = 1'b0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Single read, memory answers on the third command cycle
        obs.delete(); n_rd_cmd_cycles = 0; base_rd = n_rd_resp;
        fixed_lat = 3; pat_en = 1'b1;
        rd_read_i = 1'b1; rd_address_i = 32'h0000_1040;
        repeat (6) tick();
        pat_en = 1'b0;
        check_val("rd_cmd_cycles", 256'(n_rd_cmd_cycles), 256'd3);
        check_val("rd_resp_count", 256'(n_rd_resp - base_rd), 256'd1);
        check_val("rd_fill_data", last_rdata, {32{8'hA5}});
        exp_q = '{1};
        check_seq("single_rd_seq", exp_q);

        // Single write
        obs.delete(); base_wb = n_wb_resp;
        fixed_lat = 2;
        wb_write_i = 1'b1; wb_address_i = 32'h0000_2000;
        wb_wdata_i = {8{32'h1234_5678}};
        repeat (5) tick();
        check_val("wb_resp_count", 256'(n_wb_resp - base_wb), 256'd1);
        exp_q = '{2};
        check_seq("single_wb_seq", exp_q);

        // RAW hazard: same line, write must reach memory first
        obs.delete();
        fixed_lat = 1;
        rd_read_i = 1'b1; rd_address_i = 32'h0000_3004;
        wb_write_i = 1'b1; wb_address_i = 32'h0000_3018; wb_wdata_i = rand_line();
        repeat (8) tick();
        exp_q = '{2, 1};
        check_seq("raw_seq", exp_q);

        // Starvation bound: reads keep coming while writes wait
        obs.delete();
        fixed_lat = 1;
        reads_left = 9; writes_left = 2;
        rd_read_i = 1'b1; rd_address_i = 32'h0000_6000; reads_left--;
        wb_write_i = 1'b1; wb_address_i = 32'h0000_5000; wb_wdata_i = rand_line(); writes_left--;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (!rd_read_i && reads_left > 0) begin
                rd_read_i = 1'b1;
                rd_address_i = 32'h0000_6000 + 32'((9 - reads_left) * 64);
                reads_left--;
            end
            if (!wb_write_i && writes_left > 0) begin
                wb_write_i = 1'b1; wb_address_i = 32'h0000_5020; wb_wdata_i = rand_line();
                writes_left--;
            end
        end
        exp_q = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1};
        check_seq("starve_seq", exp_q);

        // Reset in the middle of a write, then a stray memory response
        fixed_lat = 20; base_wb = n_wb_resp;
        wb_write_i = 1'b1; wb_address_i = 32'h0000_4000; wb_wdata_i = rand_line();
        repeat (3) tick();
        rst = 1'b1; wb_write_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        force_idle_resp = 1'b1;
        repeat (2) tick();
        force_idle_resp = 1'b0;
        check_val("rst_no_wb_resp", 256'(n_wb_resp - base_wb), 256'd0);

        // Randomised traffic, random memory latency 1..8, idle-time noise
        fixed_lat = 0; idle_noise = 1'b1;
        base_rd = n_rd_resp; base_wb = n_wb_resp;
        issued_rd = 0; issued_wb = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!rd_read_i && $urandom_range(0, 2) == 0) begin
                rd_read_i = 1'b1;
                rd_address_i = 32'h0000_7000 | 32'($urandom_range(0, 3) << 5) | 32'($urandom_range(0, 31));
                issued_rd++;
            end
            if (!wb_write_i && $urandom_range(0, 3) == 0) begin
                wb_write_i = 1'b1;
                wb_address_i = 32'h0000_7000 | 32'($urandom_range(0, 3) << 5) | 32'($urandom_range(0, 31));
                wb_wdata_i = rand_line();
                issued_wb++;
            end
            tick();
        end
        for (int c = 0; c < 60; c++) tick();
        check_val("rand_rd_done", 256'(n_rd_resp - base_rd), 256'(issued_rd));
        check_val("rand_wb_done", 256'(n_wb_resp - base_wb), 256'(issued_wb));
        check_val("rand_rd_idle", 256'(rd_read_i), 256'h0);
        check_val("rand_wb_idle", 256'(wb_write_i), 256'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
